vending_controller: RTL and testbench
=====================================

# vending_controller

Sequencing FSM for the vending machine transaction path. Accumulates inserted coins, latches the item selection and its price, checks funds, then fires a one-cycle `end_trans` strobe. It drives `output_handler` (item decoder and change subtractor) with stable `sum_money`, `price` and `item_select`. It also handles cancel, inactivity timeout and coin overflow with a refund/reject path that never touches `end_trans`.

## Interface
- `PRICE_0`, default 8'd15, price of item 0
- `PRICE_1`, default 8'd20, price of item 1
- `PRICE_2`, default 8'd25, price of item 2
- `PRICE_3`, default 8'd30, price of item 3
- `TIMEOUT`, default 1000, idle cycles in COLLECT before automatic refund (≥2)
- `clk`  in  1  single system clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `coin_valid`  in  1  one-cycle strobe: coin present on `coin_value`
- `coin_value`  in  8  value of inserted coin (0 treated as no coin)
- `sel_valid`  in  1  one-cycle strobe: selection present on `sel_item`
- `sel_item`  in  2  requested item index
- `cancel`  in  1  one-cycle strobe: abort and refund
- `sum_money`  out  8  accumulated credit, to `output_handler`
- `price`  out  8  latched price of selected item, to `output_handler`
- `item_select`  out  2  latched item index, to `output_handler`
- `end_trans`  out  1  one-cycle dispense strobe, to `output_handler`
- `refund_valid`  out  1  one-cycle strobe: return `refund_amount`
- `refund_amount`  out  8  credit returned on cancel/timeout
- `coin_reject`  out  1  one-cycle strobe: current coin refused
- `insufficient`  out  1  one-cycle strobe: selection refused, credit too low
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, COLLECT, CHECK, DISPENSE, REFUND. Registered outputs only.
- IDLE: `sum_money`=0. `coin_valid` with nonzero value → sum=coin, go COLLECT. `sel_valid` and `cancel` ignored.
- COLLECT, priority cancel > coin > select:
  - `cancel` → REFUND.
  - else `coin_valid`: if sum+coin ≤ 255 add it (9-bit compare, no wrap); else sum unchanged, `coin_reject`=1 next cycle. A coin in the same cycle as `sel_valid` drops the selection; it must be re-presented.
  - else `sel_valid` → latch `item_select`=sel_item, `price`=PRICE_n, go CHECK.
  - Inactivity counter clears on any accepted or rejected coin, selection or entry to COLLECT; at TIMEOUT-1 with no event → REFUND.
- CHECK (1 cycle): sum ≥ price → DISPENSE; else `insufficient`=1, back to COLLECT, counter cleared, `price`/`item_select` keep last values.
- DISPENSE (1 cycle): `end_trans`=1; `sum_money`, `price`, `item_select` stable during the strobe. All inputs ignored. Next: IDLE, `sum_money`=0, `price`=0.
- REFUND (1 cycle): `refund_valid`=1, `refund_amount`=sum; `end_trans` stays 0. Next: IDLE, sum=0. Inputs ignored.
- Change computation (sum−price) is done downstream; this block guarantees sum ≥ price whenever `end_trans`=1.

## Timing
- Reset (rst_n=0 at a clock edge): state IDLE; `sum_money`, `price`, `refund_amount`=0; `item_select`=0; `end_trans`, `refund_valid`, `coin_reject`, `insufficient`, `busy`=0; timeout counter 0. Reset mid-transaction discards credit silently; no refund strobe.
- Coin accepted at edge N → `sum_money` updated after edge N.
- Selection at edge N → CHECK after N, `end_trans` high in cycle after N+1 (2-cycle select-to-dispense latency), IDLE after N+2.
- All strobes are exactly one cycle. `end_trans` and `refund_valid` are never high together.
- `busy` reflects the registered state.

## Test plan
- Reset, then coins 10,10 then sel_item=1 (price 20) → sum 20, `end_trans` one cycle 2 cycles after select, item_select=1, price=20, then sum=0.
- Coin 10, select item 3 (30) → `insufficient` pulse, state COLLECT; coin 20, select 3 → `end_trans` with sum 30.
- Coins 200 then 100 → `coin_reject` pulse, sum stays 200; `cancel` → `refund_valid` with amount 200, no `end_trans`.
- Coin 5, then TIMEOUT idle cycles (TIMEOUT=8 in bench) → `refund_valid`, amount 5 exactly after 8 idle cycles; coin at cycle 7 restarts count.
- Same-cycle coin 25 + select 2 → coin added (sum 25), no CHECK; same-cycle cancel + coin → refund of prior sum, coin ignored.
- rst_n low during CHECK with sum 40 → all outputs zero next cycle, no strobes; `sel_valid` in IDLE → no state change.

Source files
------------

// File: rtl/vending_controller.sv
`default_nettype none
// ============================================================================
// vending_controller : coin/selection sequencing FSM feeding output_handler.
// Revision 1.0
// ============================================================================
module vending_controller #(
    parameter logic [7:0] PRICE_0 = 8'd15,
    parameter logic [7:0] PRICE_1 = 8'd20,
    parameter logic [7:0] PRICE_2 = 8'd25,
    parameter logic [7:0] PRICE_3 = 8'd30,
    parameter int         TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [7:0] coin_value,
    input  logic       sel_valid,
    input  logic [1:0] sel_item,
    input  logic       cancel,
    output logic [7:0] sum_money,
    output logic [7:0] price,
    output logic [1:0] item_select,
    output logic       end_trans,
    output logic       refund_valid,
    output logic [7:0] refund_amount,
    output logic       coin_reject,
    output logic       insufficient,
    output logic       busy
);

    localparam int unsigned c_cnt_w = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_CHECK    = 3'd2,
        ST_DISPENSE = 3'd3,
        ST_REFUND   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_sum,       w_sum_nxt;
    logic [7:0]         r_price,     w_price_nxt;
    logic [1:0]         r_item,      w_item_nxt;
    logic [7:0]         r_ref_amt,   w_ref_amt_nxt;
    logic [c_cnt_w-1:0] r_cnt,       w_cnt_nxt;
    logic               r_end,       w_end_nxt;
    logic               r_ref_vld,   w_ref_vld_nxt;
    logic               r_reject,    w_reject_nxt;
    logic               r_insuf,     w_insuf_nxt;
    logic               r_busy;

    logic               w_coin;
    logic [8:0]         w_sum_add;
    logic [7:0]         w_sel_price;

    // A zero-valued coin is not an event at all: it neither adds credit nor
    // masks a selection nor restarts the inactivity count.
    assign w_coin    = coin_valid && (coin_value != 8'd0);
    assign w_sum_add = {1'b0, r_sum} + {1'b0, coin_value};

    always_comb begin
        w_sel_price = PRICE_0;
        case (sel_item)
            2'd0:    w_sel_price = PRICE_0;
            2'd1:    w_sel_price = PRICE_1;
            2'd2:    w_sel_price = PRICE_2;
            default: w_sel_price = PRICE_3;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sum_nxt     = r_sum;
        w_price_nxt   = r_price;
        w_item_nxt    = r_item;
        w_ref_amt_nxt = r_ref_amt;
        w_cnt_nxt     = r_cnt;
        w_end_nxt     = 1'b0;
        w_ref_vld_nxt = 1'b0;
        w_reject_nxt  = 1'b0;
        w_insuf_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_sum_nxt = 8'd0;
                w_cnt_nxt = '0;
                if (w_coin) begin
                    w_sum_nxt   = coin_value;
                    w_state_nxt = ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                if (cancel) begin
                    w_state_nxt   = ST_REFUND;
                    w_ref_vld_nxt = 1'b1;
                    w_ref_amt_nxt = r_sum;
                    w_cnt_nxt     = '0;
                end else if (w_coin) begin
                    w_cnt_nxt = '0;
                    if (w_sum_add[8]) begin
                        w_reject_nxt = 1'b1;
                    end else begin
                        w_sum_nxt = w_sum_add[7:0];
                    end
                end else if (sel_valid) begin
                    w_item_nxt  = sel_item;
                    w_price_nxt = w_sel_price;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_CHECK;
                end else if (r_cnt == c_tmo_last) begin
                    w_state_nxt   = ST_REFUND;
                    w_ref_vld_nxt = 1'b1;
                    w_ref_amt_nxt = r_sum;
                    w_cnt_nxt     = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_CHECK: begin
                w_cnt_nxt = '0;
                if (r_sum >= r_price) begin
                    w_state_nxt = ST_DISPENSE;
                    w_end_nxt   = 1'b1;
                end else begin
                    w_state_nxt = ST_COLLECT;
                    w_insuf_nxt = 1'b1;
                end
            end

            // sum/price/item stay put while end_trans is visible downstream.
            ST_DISPENSE: begin
                w_state_nxt = ST_IDLE;
                w_sum_nxt   = 8'd0;
                w_price_nxt = 8'd0;
            end

            ST_REFUND: begin
                w_state_nxt = ST_IDLE;
                w_sum_nxt   = 8'd0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_sum_nxt   = 8'd0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_sum     <= 8'd0;
            r_price   <= 8'd0;
            r_item    <= 2'd0;
            r_ref_amt <= 8'd0;
            r_cnt     <= '0;
            r_end     <= 1'b0;
            r_ref_vld <= 1'b0;
            r_reject  <= 1'b0;
            r_insuf   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sum     <= w_sum_nxt;
            r_price   <= w_price_nxt;
            r_item    <= w_item_nxt;
            r_ref_amt <= w_ref_amt_nxt;
            r_cnt     <= w_cnt_nxt;
            r_end     <= w_end_nxt;
            r_ref_vld <= w_ref_vld_nxt;
            r_reject  <= w_reject_nxt;
            r_insuf   <= w_insuf_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

    assign sum_money     = r_sum;
    assign price         = r_price;
    assign item_select   = r_item;
    assign end_trans     = r_end;
    assign refund_valid  = r_ref_vld;
    assign refund_amount = r_ref_amt;
    assign coin_reject   = r_reject;
    assign insufficient  = r_insuf;
    assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vending_controller.sv
`default_nettype none
// ============================================================================
// tb_vending_controller : directed self-checking bench for vending_controller.
// Revision 1.0
// ============================================================================
module tb_vending_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [7:0] coin_value = 8'd0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_item = 2'd0;
    logic       cancel = 1'b0;
    logic [7:0] sum_money;
    logic [7:0] price;
    logic [1:0] item_select;
    logic       end_trans;
    logic       refund_valid;
    logic [7:0] refund_amount;
    logic       coin_reject;
    logic       insufficient;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    vending_controller #(
        .PRICE_0(8'd15), .PRICE_1(8'd20), .PRICE_2(8'd25), .PRICE_3(8'd30),
        .TIMEOUT(8)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .coin_valid(coin_valid), .coin_value(coin_value),
        .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
        .sum_money(sum_money), .price(price), .item_select(item_select),
        .end_trans(end_trans), .refund_valid(refund_valid),
        .refund_amount(refund_amount), .coin_reject(coin_reject),
        .insufficient(insufficient), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        coin_valid = 1'b0; coin_value = 8'd0;
        sel_valid  = 1'b0; sel_item   = 2'd0;
        cancel     = 1'b0;
    endtask

    task automatic put_coin(input logic [7:0] v);
        coin_valid = 1'b1; coin_value = v;
        tick();
        clear_in();
    endtask

    task automatic put_sel(input logic [1:0] s);
        sel_valid = 1'b1; sel_item = s;
        tick();
        clear_in();
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check_eq("rst_sum", 32'(sum_money), 0);
        check_eq("rst_price", 32'(price), 0);
        check_eq("rst_item", 32'(item_select), 0);
        check_eq("rst_flags", 32'({end_trans, refund_valid, coin_reject, insufficient, busy}), 0);
        check_eq("rst_refamt", 32'(refund_amount), 0);
        rst_n = 1'b1;
        tick();

        // Zero-value coin in IDLE is no coin
        put_coin(8'd0);
        check_eq("zero_coin_busy", 32'(busy), 0);

        // 10 + 10, select item 1 (price 20)
        put_coin(8'd10);
        check_eq("s1_sum10", 32'(sum_money), 10);
        check_eq("s1_busy", 32'(busy), 1);
        put_coin(8'd10);
        check_eq("s1_sum20", 32'(sum_money), 20);
        put_sel(2'd1);
        check_eq("s1_chk_end", 32'(end_trans), 0);
        check_eq("s1_chk_price", 32'(price), 20);
        tick();
        check_eq("s1_end", 32'(end_trans), 1);
        check_eq("s1_end_sum", 32'(sum_money), 20);
        check_eq("s1_end_price", 32'(price), 20);
        check_eq("s1_end_item", 32'(item_select), 1);
        check_eq("s1_end_refv", 32'(refund_valid), 0);
        tick();
        check_eq("s1_post_end", 32'(end_trans), 0);
        check_eq("s1_post_sum", 32'(sum_money), 0);
        check_eq("s1_post_price", 32'(price), 0);
        check_eq("s1_post_busy", 32'(busy), 0);

        // Insufficient credit, then top up
        put_coin(8'd10);
        put_sel(2'd3);
        check_eq("s2_chk_price", 32'(price), 30);
        tick();
        check_eq("s2_insuf", 32'(insufficient), 1);
        check_eq("s2_insuf_end", 32'(end_trans), 0);
        check_eq("s2_insuf_busy", 32'(busy), 1);
        tick();
        check_eq("s2_insuf_pulse", 32'(insufficient), 0);
        check_eq("s2_keep_item", 32'(item_select), 3);
        put_coin(8'd20);
        check_eq("s2_sum30", 32'(sum_money), 30);
        put_sel(2'd3);
        tick();
        check_eq("s2_end", 32'(end_trans), 1);
        check_eq("s2_end_sum", 32'(sum_money), 30);
        tick();

        // Overflow reject, then cancel
        put_coin(8'd200);
        put_coin(8'd100);
        check_eq("s3_reject", 32'(coin_reject), 1);
        check_eq("s3_sum_hold", 32'(sum_money), 200);
        tick();
        check_eq("s3_reject_pulse", 32'(coin_reject), 0);
        cancel = 1'b1; tick(); clear_in();
        check_eq("s3_refv", 32'(refund_valid), 1);
        check_eq("s3_refamt", 32'(refund_amount), 200);
        check_eq("s3_no_end", 32'(end_trans), 0);
        tick();
        check_eq("s3_refv_pulse", 32'(refund_valid), 0);
        check_eq("s3_sum0", 32'(sum_money), 0);
        check_eq("s3_idle", 32'(busy), 0);

        // Timeout after 8 idle cycles
        put_coin(8'd5);
        for (int i = 0; i < 7; i++) tick();
        check_eq("s4_no_tmo_7", 32'(refund_valid), 0);
        tick();
        check_eq("s4_tmo_refv", 32'(refund_valid), 1);
        check_eq("s4_tmo_amt", 32'(refund_amount), 5);
        tick();

        // A coin on idle cycle 7 restarts the count
        put_coin(8'd5);
        for (int i = 0; i < 6; i++) tick();
        put_coin(8'd1);
        for (int i = 0; i < 7; i++) tick();
        check_eq("s4b_no_tmo", 32'(refund_valid), 0);
        check_eq("s4b_busy", 32'(busy), 1);
        tick();
        check_eq("s4b_tmo_refv", 32'(refund_valid), 1);
        check_eq("s4b_tmo_amt", 32'(refund_amount), 6);
        tick();

        // Coin + select same cycle: coin wins, selection dropped
        put_coin(8'd5);
        coin_valid = 1'b1; coin_value = 8'd25; sel_valid = 1'b1; sel_item = 2'd2;
        tick(); clear_in();
        check_eq("s5_sum30", 32'(sum_money), 30);
        check_eq("s5_price_unlatched", 32'(price), 0);
        tick();
        check_eq("s5_no_end", 32'(end_trans), 0);
        check_eq("s5_no_insuf", 32'(insufficient), 0);
        // Cancel + coin same cycle: refund prior credit, coin ignored
        cancel = 1'b1; coin_valid = 1'b1; coin_value = 8'd50;
        tick(); clear_in();
        check_eq("s5_cancel_refv", 32'(refund_valid), 1);
        check_eq("s5_cancel_amt", 32'(refund_amount), 30);
        tick();

        // Reset during CHECK
        put_coin(8'd40);
        put_sel(2'd0);
        check_eq("s6_in_check_price", 32'(price), 15);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("s6_rst_sum", 32'(sum_money), 0);
        check_eq("s6_rst_price", 32'(price), 0);
        check_eq("s6_rst_flags", 32'({end_trans, refund_valid, coin_reject, insufficient, busy}), 0);
        tick();
        check_eq("s6_no_late_end", 32'(end_trans), 0);
        put_sel(2'd2);
        check_eq("s6_idle_sel_busy", 32'(busy), 0);
        check_eq("s6_idle_sel_price", 32'(price), 0);
        check_eq("s6_idle_sel_item", 32'(item_select), 0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
